// File: rtl/idex_stage_if.sv
// idex_stage_if: valid/ready operand bus from the ID/EX stage toward EX.
interface idex_stage_if #(parameter int CTRL_W = 8);
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       ex_a;
    logic [63:0]       ex_b;
    logic [63:0]       ex_imm;
    logic [4:0]        ex_wa;
    logic [CTRL_W-1:0] ex_ctrl;
    modport master (output out_valid, ex_a, ex_b, ex_imm, ex_wa, ex_ctrl, input out_ready);
    modport slave  (input out_valid, ex_a, ex_b, ex_imm, ex_wa, ex_ctrl, output out_ready);
endinterface

// File: rtl/idex_stage.sv
// idex_stage: ID/EX skid-buffered stage with write-back bypass and XZR forcing.
// Define IDEX_SNOOP_EN to let held entries pick up later write-backs.
module idex_stage #(parameter int CTRL_W = 8) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [63:0]       rd1,
    input  logic [63:0]       rd2,
    input  logic [63:0]       imm,
    input  logic [4:0]        wa,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              wb_we3,
    input  logic [4:0]        wb_wa3,
    input  logic [63:0]       wb_wd3,
    input  logic              flush,
    idex_stage_if.master      ex
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [63:0]       a;
        logic [63:0]       b;
        logic [63:0]       imm;
        logic [4:0]        wa;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        ra1;
        logic [4:0]        ra2;
    } entry_t;
`ifdef IDEX_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif
    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, main_s, skid_s, in_e;
    logic   wb_hit, push, pop;

    function automatic entry_t snoop(input entry_t e, input logic hit, input logic [4:0] wa3,
                                     input logic [63:0] wd3);
        entry_t r;
        r = e;
        if (hit && e.ra1 == wa3) r.a = wd3;
        if (hit && e.ra2 == wa3) r.b = wd3;
        return r;
    endfunction

    always_comb begin
        // X31 never matches a write, so a hit also excludes XZR writes
        wb_hit     = wb_we3 && wb_wa3 != 5'd31;
        in_e.a     = (ra1 == 5'd31) ? 64'd0 : (wb_hit && wb_wa3 == ra1) ? wb_wd3 : rd1;
        in_e.b     = (ra2 == 5'd31) ? 64'd0 : (wb_hit && wb_wa3 == ra2) ? wb_wd3 : rd2;
        in_e.imm   = imm;
        in_e.wa    = wa;
        in_e.ctrl  = ctrl;
        in_e.ra1   = ra1;
        in_e.ra2   = ra2;
        main_s     = (SNOOP && state_q != EMPTY) ? snoop(main_q, wb_hit, wb_wa3, wb_wd3) : main_q;
        skid_s     = (SNOOP && state_q == FULL) ? snoop(skid_q, wb_hit, wb_wa3, wb_wd3) : skid_q;
        push       = in_valid && state_q != FULL;
        pop        = state_q != EMPTY && ex.out_ready;
        state_d    = state_q;
        main_d     = main_s;
        skid_d     = skid_s;
        case (state_q)
            EMPTY: if (push) begin
                state_d = ONE;
                main_d  = in_e;
            end
            ONE: if (push && pop) main_d = in_e;
                 else if (push) begin
                     state_d = FULL;
                     skid_d  = in_e;
                 end else if (pop) state_d = EMPTY;
            FULL: if (pop) begin
                state_d = ONE;
                main_d  = skid_s;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready     = state_q != FULL;
    assign ex.out_valid = state_q != EMPTY;
    assign ex.ex_a      = main_q.a;
    assign ex.ex_b      = main_q.b;
    assign ex.ex_imm    = main_q.imm;
    assign ex.ex_wa     = main_q.wa;
    assign ex.ex_ctrl   = main_q.ctrl;
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed and randomized checks of idex_stage against a queue model.
module tb_idex_stage;
    typedef struct {
        logic [63:0] a, b, imm;
        logic [4:0]  wa, ra1, ra2;
        logic [7:0]  ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, wb_we3, flush;
    logic [4:0]  ra1, ra2, wa, wb_wa3;
    logic [63:0] rd1, rd2, imm, wb_wd3;
    logic [7:0]  ctrl;
    ent_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    idex_stage_if #(.CTRL_W(8)) ex();

    idex_stage #(.CTRL_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .imm(imm), .wa(wa), .ctrl(ctrl),
        .wb_we3(wb_we3), .wb_wa3(wb_wa3), .wb_wd3(wb_wd3), .flush(flush), .ex(ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] operand(input logic [4:0] ra, input logic [63:0] rd);
        if (ra == 31) return 64'd0;
        if (wb_we3 && wb_wa3 == ra && wb_wa3 != 31) return wb_wd3;
        return rd;
    endfunction

    task automatic model_step();
        ent_t e;
        bit   do_push, do_pop;
        if (flush) begin
            q.delete();
            return;
        end
        do_push = in_valid && q.size() < 2;
        do_pop  = q.size() > 0 && ex.out_ready;
`ifdef IDEX_SNOOP_EN
        foreach (q[i]) if (wb_we3 && wb_wa3 != 31) begin
            if (q[i].ra1 == wb_wa3) q[i].a = wb_wd3;
            if (q[i].ra2 == wb_wa3) q[i].b = wb_wd3;
        end
`endif
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            e = '{a: operand(ra1, rd1), b: operand(ra2, rd2), imm: imm, wa: wa,
                  ra1: ra1, ra2: ra2, ctrl: ctrl};
            q.push_back(e);
        end
    endtask

    task automatic compare();
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(ex.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("ex_a", ex.ex_a, q[0].a);
            chk("ex_b", ex.ex_b, q[0].b);
            chk("ex_imm", ex.ex_imm, q[0].imm);
            chk("ex_wa", 64'(ex.ex_wa), 64'(q[0].wa));
            chk("ex_ctrl", 64'(ex.ex_ctrl), 64'(q[0].ctrl));
        end
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [63:0] d1, input logic [63:0] d2);
        in_valid = v; ra1 = r1; ra2 = r2; rd1 = d1; rd2 = d2;
        imm = {$urandom, $urandom}; wa = 5'($urandom); ctrl = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_we3 = 1'b0; wb_wa3 = '0; wb_wd3 = '0;
        ex.out_ready = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(ex.out_valid), 64'd0);
        chk("rst_ex_a", ex.ex_a, 64'd0);
        chk("rst_ex_b", ex.ex_b, 64'd0);
        chk("rst_ex_imm", ex.ex_imm, 64'd0);
        chk("rst_ex_wa_ctrl", 64'({ex.ex_wa, ex.ex_ctrl}), 64'd0);
        set_in(1'b1, 5'd3, 5'd4, 64'd3, 64'd4);
        cyc();
        chk("basic_valid", 64'(ex.out_valid), 64'd1);
        chk("basic_a", ex.ex_a, 64'd3);
        chk("basic_b", ex.ex_b, 64'd4);
        set_in(1'b1, 5'd5, 5'd6, 64'h1111, 64'h2222);
        wb_we3 = 1'b1; wb_wa3 = 5'd5; wb_wd3 = 64'hABCD;
        cyc();
        chk("bypass_a", ex.ex_a, 64'hABCD);
        chk("bypass_b", ex.ex_b, 64'h2222);
        set_in(1'b1, 5'd31, 5'd6, 64'h1234, 64'h2222);
        wb_wa3 = 5'd31;
        cyc();
        chk("xzr_a", ex.ex_a, 64'd0);
        wb_we3 = 1'b0; in_valid = 1'b0;
        cyc();
        ex.out_ready = 1'b0;
        set_in(1'b1, 5'd1, 5'd7, 64'h22, 64'h11);
        cyc();
        chk("stall1_in_ready", 64'(in_ready), 64'd1);
        set_in(1'b1, 5'd8, 5'd9, 64'h88, 64'h99);
        cyc();
        chk("stall2_in_ready", 64'(in_ready), 64'd0);
        set_in(1'b1, 5'd10, 5'd11, 64'hAA, 64'hBB);
        cyc();
        chk("stall3_head_a", ex.ex_a, 64'h22);
        in_valid = 1'b0; wb_we3 = 1'b1; wb_wa3 = 5'd7; wb_wd3 = 64'h55;
        cyc();
        wb_we3 = 1'b0; ex.out_ready = 1'b1;
`ifdef IDEX_SNOOP_EN
        chk("snoop_b", ex.ex_b, 64'h55);
`else
        chk("frozen_b", ex.ex_b, 64'h11);
`endif
        cyc();
        chk("pop2_a", ex.ex_a, 64'h88);
        chk("pop2_b", ex.ex_b, 64'h99);
        cyc();
        chk("drained", 64'(ex.out_valid), 64'd0);
        ex.out_ready = 1'b0;
        set_in(1'b1, 5'd2, 5'd3, 64'h1, 64'h2);
        cyc();
        set_in(1'b1, 5'd4, 5'd5, 64'h3, 64'h4);
        cyc();
        flush = 1'b1;
        set_in(1'b1, 5'd6, 5'd7, 64'h5, 64'h6);
        cyc();
        chk("flush_valid", 64'(ex.out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; ex.out_ready = 1'b1;
        cyc();
        chk("flush_nodeliver", 64'(ex.out_valid), 64'd0);
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom % 4 != 0,
                   ($urandom % 5 == 0) ? 5'd31 : 5'($urandom % 8),
                   ($urandom % 5 == 0) ? 5'd31 : 5'($urandom % 8),
                   {$urandom, $urandom}, {$urandom, $urandom});
            ex.out_ready = $urandom % 3 != 0;
            flush = $urandom % 40 == 0;
            wb_we3 = $urandom % 2 == 0;
            wb_wa3 = ($urandom % 2 == 0) ? ra1 : ($urandom % 6 == 0) ? 5'd31 : 5'($urandom % 8);
            wb_wd3 = {$urandom, $urandom};
            cyc();
        end
        flush = 1'b0; wb_we3 = 1'b0; ex.out_ready = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 64'h7, 64'h8);
        cyc();
        cyc();
        cyc();
        chk("pre_areset_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", 64'(ex.out_valid), 64'd0);
        chk("areset_ready", 64'(in_ready), 64'd1);
        chk("areset_ex_a", ex.ex_a, 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        ex.out_ready = 1'b1;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
